// File: rtl/ustream_bi_decoder.sv
// ustream_bi_decoder
//   Bipolar unary-stream to binary decoder. Counts the 1s in a serial stream
//   over a window of 2**WIDTH valid bits. Returns ones - 2**(WIDTH-1) as a
//   signed WIDTH-bit value. The single positive overflow case (+2**(WIDTH-1))
//   saturates to the largest positive value.
//
//   Ports
//     clk     rising-edge clock
//     rst     asynchronous, active-high reset
//     iStart  begin a window (honoured in IDLE only)
//     iClr    synchronous abort of the window in progress (RUN only)
//     iValid  qualifies iBit; bubbles stretch the window
//     iBit    stream bit (1 = +1, 0 = -1)
//     oBusy   high while in RUN
//     oDone   one-cycle pulse, coincident with the new oC
//     oC      decoded signed value, held until the next oDone
//
//   Build option
//     USTREAM_DEC_CONT_EN : continuous mode. The FSM stays in RUN and starts
//     the next window on the next valid bit. oDone pulses once per window.
module ustream_bi_decoder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iStart,
  input  logic             iClr,
  input  logic             iValid,
  input  logic             iBit,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oC
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [WIDTH:0]   LAST    = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0] HALF    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  state_t           state_q, state_d;
  logic [WIDTH:0]   cnt_q, cnt_d;
  logic [WIDTH:0]   ones_q, ones_d;
  logic [WIDTH-1:0] oc_q, oc_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sat;

  // Final count including the bit on the input this cycle. Only
  // sum == 2**WIDTH sets the top bit, which is the one saturating case.
  // Otherwise the modulo-2**WIDTH difference is exact.
  assign sum = ones_q + (WIDTH+1)'(iBit);
  assign sat = sum[WIDTH] ? POS_MAX : (sum[WIDTH-1:0] - HALF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ones_q  <= '0;
      oc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      oc_q    <= oc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    oc_d    = oc_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (iStart && !iClr) begin
          state_d = S_RUN;
          cnt_d   = '0;
          ones_d  = '0;
        end
      end
      S_RUN: begin
        if (iClr) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          ones_d  = '0;
        end else if (iValid) begin
          if (cnt_q == LAST) begin
            // oDone is a registered pulse in both modes. In single-shot mode
            // it coincides with the DONE state cycle.
            oc_d   = sat;
            done_d = 1'b1;
            cnt_d  = '0;
            ones_d = '0;
`ifndef USTREAM_DEC_CONT_EN
            state_d = S_DONE;
`endif
          end else begin
            cnt_d  = cnt_q + 1'b1;
            ones_d = sum;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign oBusy = (state_q == S_RUN);
  assign oDone = done_q;
  assign oC    = oc_q;

endmodule

// File: tb/tb_ustream_bi_decoder.sv
module tb_ustream_bi_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iStart = 1'b0;
  logic       iClr = 1'b0;
  logic       iValid = 1'b0;
  logic       iBit = 1'b0;
  logic       oBusy;
  logic       oDone;
  logic [7:0] oC;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_done_cyc = -1;
  logic [7:0] exp_q[$];

  ustream_bi_decoder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .iStart(iStart), .iClr(iClr),
    .iValid(iValid), .iBit(iBit), .oBusy(oBusy), .oDone(oDone), .oC(oC)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every oDone pops one expected oC
  always @(negedge clk) begin
    if (!rst && oDone === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(oDone), 32'd0);
      end else begin
        chk("oC_at_done", 32'(oC), 32'(exp_q.pop_front()));
      end
`ifdef USTREAM_DEC_CONT_EN
      if (last_done_cyc >= 0) chk("done_interval", 32'(cyc - last_done_cyc), 32'd256);
      last_done_cyc = cyc;
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         n_ones;
    bit         alt;
    bit         bubbles;
    bit         start_mid;
    bit         clr_in_done;
    logic [7:0] exp;
  } vec_t;

  task automatic run_window(input vec_t v, input int id);
    int sent = 0;
    int c = 0;
    int d0 = done_cnt;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    chk($sformatf("w%0d_busy_start", id), 32'(oBusy), 32'd1);
    while (sent < 256) begin
      if (v.bubbles && (c % 3 == 2)) begin
        iValid = 1'b0;
        iBit   = 1'($urandom_range(0, 1));
      end else begin
        iValid = 1'b1;
        iBit   = v.alt ? (sent % 2 == 0) : (sent < v.n_ones);
        if (sent == 255) exp_q.push_back(v.exp);
        sent++;
      end
      iStart = v.start_mid && (sent == 50);
      c++;
      step();
      iStart = 1'b0;
      if (sent < 256) begin
        chk($sformatf("w%0d_busy_run", id), 32'(oBusy), 32'd1);
        chk($sformatf("w%0d_no_early_done", id), 32'(done_cnt - d0), 32'd0);
      end
    end
    iValid = 1'b0;
    iClr   = v.clr_in_done;
    chk($sformatf("w%0d_busy_in_done", id), 32'(oBusy), 32'd0);
    step();
    iClr = 1'b0;
    chk($sformatf("w%0d_done_once", id), 32'(done_cnt - d0), 32'd1);
    chk($sformatf("w%0d_oC_held", id), 32'(oC), 32'(v.exp));
    chk($sformatf("w%0d_busy_after", id), 32'(oBusy), 32'd0);
  endtask

  vec_t vecs[7];
  int   d0;

  initial begin
    vecs[0] = '{256, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F}; // all ones, saturates
    vecs[1] = '{0,   1'b0, 1'b0, 1'b0, 1'b0, 8'h80}; // all zeros
    vecs[2] = '{0,   1'b1, 1'b1, 1'b0, 1'b0, 8'h00}; // alternating, bubbles
    vecs[3] = '{255, 1'b0, 1'b0, 1'b1, 1'b0, 8'h7F}; // +127 exact, iStart mid-run
    vecs[4] = '{127, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF}; // -1, iClr in DONE
    vecs[5] = '{129, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01}; // +1
    vecs[6] = '{192, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40}; // 192 ones, 64 zeros

    #1;
    chk("reset_busy", 32'(oBusy), 32'd0);
    chk("reset_done", 32'(oDone), 32'd0);
    chk("reset_oC", 32'(oC), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

`ifndef USTREAM_DEC_CONT_EN
    foreach (vecs[i]) run_window(vecs[i], i);

    // Abort at bit 100; iClr wins over iValid on the same edge
    d0 = done_cnt;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    for (int b = 0; b < 100; b++) begin
      iValid = 1'b1;
      iBit   = 1'b1;
      step();
    end
    iClr = 1'b1;
    step();
    iClr = 1'b0;
    chk("clr_busy", 32'(oBusy), 32'd0);
    chk("clr_oC_held", 32'(oC), 32'h40);
    for (int b = 0; b < 300; b++) step();  // valid bits in IDLE are ignored
    iValid = 1'b0;
    chk("clr_no_done", 32'(done_cnt - d0), 32'd0);
    run_window('{129, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01}, 10);

    // iStart and iClr together in IDLE stay IDLE
    iStart = 1'b1;
    iClr   = 1'b1;
    step();
    iStart = 1'b0;
    iClr   = 1'b0;
    step();
    chk("start_clr_idle", 32'(oBusy), 32'd0);

    // Reset at bit 50 discards the window
    d0 = done_cnt;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    for (int b = 0; b < 50; b++) begin
      iValid = 1'b1;
      iBit   = 1'b1;
      step();
    end
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_oC", 32'(oC), 32'd0);
    chk("rst_done", 32'(oDone), 32'd0);
    step();
    rst = 1'b0;
    for (int b = 0; b < 300; b++) step();
    iValid = 1'b0;
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rst_busy_after", 32'(oBusy), 32'd0);
    run_window('{0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h80}, 11);
`else
    // Three back-to-back windows with iValid held high
    d0 = done_cnt;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    for (int w = 0; w < 3; w++) begin
      for (int b = 0; b < 256; b++) begin
        iValid = 1'b1;
        iBit   = (w == 0) ? 1'b1 : (w == 1) ? 1'b0 : (b < 128);
        if (b == 255) exp_q.push_back((w == 0) ? 8'h7F : (w == 1) ? 8'h80 : 8'h00);
        step();
        chk("cont_busy", 32'(oBusy), 32'd1);
      end
    end
    iValid = 1'b0;
    step();
    step();
    chk("cont_done_count", 32'(done_cnt - d0), 32'd3);
    chk("cont_oC_last", 32'(oC), 32'h00);
    iClr = 1'b1;
    step();
    iClr = 1'b0;
    chk("cont_clr_idle", 32'(oBusy), 32'd0);
`endif

    step();
    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
